mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sequencer for the MAR/MDR memory port of the datapath. Accepts one read or write command from
//  the control unit, loads MAR from the bus, drives the memory strobe, waits for mem_ready and
//  steers the MDR mux/load (MD_Mux select + MDRin) so read data lands in MDR. Adds a bounded
//  wait timeout and a single-cycle done/err report; one transaction in flight at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles waiting on mem_ready before abort (1..255)
//  CNT_W           8   width of wait counter; must hold TIMEOUT_CYCLES
// PORTS
//  clock      in   1   system clock, all state updates on posedge
//  reset      in   1   synchronous, active-low reset
//  rd_req     in   1   read command; sampled only in IDLE
//  wr_req     in   1   write command; sampled only in IDLE
//  mem_ready  in   1   memory completion pulse/level
//  MARin      out  1   load MAR from BusMuxOut
//  MDRin      out  1   load enable to MDR register
//  MDR_sel    out  1   MD_Mux select: 1 = mdata_in (memory), 0 = BusMuxOut
//  MDRout     out  1   drive MDR onto bus / memory data-in during write
//  mem_read   out  1   memory read strobe
//  mem_write  out  1   memory write strobe
//  busy       out  1   high in every state except IDLE
//  done       out  1   1-cycle pulse: transaction completed OK
//  err        out  1   1-cycle pulse: timeout abort
// BEHAVIOUR
//  - All outputs registered-state decoded (Moore); reset (reset==0 at posedge) -> IDLE, all outputs 0,
//    wait counter 0; reset mid-transaction aborts with no done/err pulse.
//  - States: IDLE, MAR_LD, RD_WAIT, RD_CAP, WR_WAIT, FIN, FAIL.
//  - IDLE: rd_req -> MAR_LD(read); wr_req only -> MAR_LD(write); both high -> read wins, write
//    dropped (requester must re-assert). No request -> stay.
//  - MAR_LD (1 cycle): MARin=1. Write: also MDRin=1, MDR_sel=0 (capture bus write data). Next:
//    RD_WAIT or WR_WAIT; counter cleared.
//  - RD_WAIT: mem_read=1, MDR_sel=1. mem_ready=1 -> RD_CAP. Else counter++; counter reaching
//    TIMEOUT_CYCLES-1 without ready -> FAIL.
//  - RD_CAP (1 cycle): MDR_sel=1, MDRin=1, mem_read=1 (data held); -> FIN.
//  - WR_WAIT: mem_write=1, MDRout=1. mem_ready=1 -> FIN; timeout as RD_WAIT -> FAIL.
//  - FIN: done=1 one cycle -> IDLE. FAIL: err=1 one cycle -> IDLE. Strobes low in FIN/FAIL.
//  - mem_ready ignored in IDLE/MAR_LD/RD_CAP/FIN/FAIL. Counter saturates, never wraps.
//  - Latency with ready on first wait cycle: read req->done = 4 cycles (MAR_LD,RD_WAIT,RD_CAP,FIN);
//    write req->done = 3 cycles. Earliest next command accepted the cycle after FIN/FAIL.
//  - MARin, MDRin never high together with mem_write/MDRout in same cycle except as listed.
// TESTING
//  1 Reset: hold reset=0 3 cycles with rd_req=1 -> all outputs 0, busy=0; release -> MAR_LD next.
//  2 Read, mem_ready high on 3rd RD_WAIT cycle -> MARin 1 cyc, mem_read 4 cyc, MDRin+MDR_sel=1 in
//    RD_CAP, done pulse exactly 1 cycle, MDR holds mdata_in=32'hDEAD_BEEF.
//  3 Write with BusMuxOut=32'h0000_1234, ready on 1st WR_WAIT -> MDRin with MDR_sel=0 in MAR_LD,
//    mem_write+MDRout 1 cyc, done 3 cycles after req.
//  4 rd_req and wr_req same cycle -> read sequence only, mem_write never asserted.
//  5 TIMEOUT_CYCLES=4, mem_ready held 0 -> 4 RD_WAIT cycles, err pulse 1 cyc, no MDRin, no done.
//  6 Reset asserted in RD_WAIT -> IDLE next cycle, mem_read=0, no done/err; new read runs cleanly.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Sequencer for the MAR/MDR memory port: loads MAR, strobes memory, waits for
// mem_ready (bounded by a timeout) and steers the MDR mux/load for reads/writes.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic rd_req,
  input  logic wr_req,
  input  logic mem_ready,
  output logic MARin,
  output logic MDRin,
  output logic MDR_sel,
  output logic MDRout,
  output logic mem_read,
  output logic mem_write,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MAR_LD  = 3'd1,
    RD_WAIT = 3'd2,
    RD_CAP  = 3'd3,
    WR_WAIT = 3'd4,
    FIN     = 3'd5,
    FAIL    = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             is_wr;
  logic             is_wr_nxt;
  logic             accept;
  logic             timeout_hit;
  logic [CNT_W-1:0] wait_cnt;

  assign accept      = (state == IDLE) && (rd_req || wr_req);
  assign timeout_hit = (wait_cnt >= CNT_LAST);

  // Next-state decode; read wins when both requests arrive together
  always_comb begin
    state_nxt = state;
    is_wr_nxt = accept ? !rd_req : is_wr;
    case (state)
      IDLE:    if (accept) state_nxt = MAR_LD;
      MAR_LD:  state_nxt = is_wr ? WR_WAIT : RD_WAIT;
      RD_WAIT: begin
        if (mem_ready)        state_nxt = RD_CAP;
        else if (timeout_hit) state_nxt = FAIL;
      end
      RD_CAP:  state_nxt = FIN;
      WR_WAIT: begin
        if (mem_ready)        state_nxt = FIN;
        else if (timeout_hit) state_nxt = FAIL;
      end
      FIN:     state_nxt = IDLE;
      FAIL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, direction flag, saturating wait counter and Moore outputs decoded from next state
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      wait_cnt  <= '0;
      MARin     <= 1'b0;
      MDRin     <= 1'b0;
      MDR_sel   <= 1'b0;
      MDRout    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      is_wr <= is_wr_nxt;
      if (state == MAR_LD)
        wait_cnt <= '0;
      else if ((state == RD_WAIT || state == WR_WAIT) && !mem_ready && wait_cnt != CNT_MAX)
        wait_cnt <= wait_cnt + CNT_W'(1);
      MARin     <= (state_nxt == MAR_LD);
      MDRin     <= ((state_nxt == MAR_LD) && is_wr_nxt) || (state_nxt == RD_CAP);
      MDR_sel   <= (state_nxt == RD_WAIT) || (state_nxt == RD_CAP);
      MDRout    <= (state_nxt == WR_WAIT);
      mem_read  <= (state_nxt == RD_WAIT) || (state_nxt == RD_CAP);
      mem_write <= (state_nxt == WR_WAIT);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == FIN);
      err       <= (state_nxt == FAIL);
    end
  end

endmodule
